// File: rtl/io_write_arbiter_if.sv
// Bundle between the write requesters, the arbiter and the I/O register file write port.
`timescale 1ns/1ps

interface io_write_arbiter_if #(
    parameter int M = 2,
    parameter int N = 5,
    parameter int T = 8
);
  logic [M-1:0]   req;
  logic [M*N-1:0] req_sel;
  logic [M*T-1:0] req_data;
  logic [M-1:0]   ack;
  logic           err;
  logic           busy;
  logic           habilitar;
  logic [N-1:0]   entradaDeco;
  logic [T-1:0]   data_IO_out;

  modport master (
    output req, req_sel, req_data,
    input  ack, err, busy, habilitar, entradaDeco, data_IO_out
  );

  modport slave (
    input  req, req_sel, req_data,
    output ack, err, busy, habilitar, entradaDeco, data_IO_out
  );
endinterface

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter for the single write port of the I/O register file.
// Optional owner locking is compiled in with the IO_ARB_LOCK_EN macro.
`timescale 1ns/1ps

module io_write_arbiter #(
  parameter int R = 2,
  parameter int N = 5,
  parameter int T = 8,
  parameter int M = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef IO_ARB_LOCK_EN
  input  logic [M-1:0]         lock,
`endif
  io_write_arbiter_if.slave    bus
);

  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam logic [PW:0] M_L = (PW+1)'(M);
  localparam logic [N:0]  R_L = (N+1)'(R);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    HOLD   = 2'd2
`ifdef IO_ARB_LOCK_EN
    , LOCKED = 2'd3
`endif
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic [PW-1:0]   grant_r, grant_s;
  logic [M-1:0]    ack_r, ack_s;
  logic            err_r, err_s;
  logic            busy_r, busy_s;
  logic            hab_r, hab_s;
  logic [N-1:0]    deco_r, deco_s;
  logic [T-1:0]    data_r, data_s;
`ifdef IO_ARB_LOCK_EN
  logic            lockhold_r, lockhold_s;
`endif

  logic            found_s;
  logic [PW-1:0]   search_s;
  logic [PW-1:0]   cap_idx_s;
  logic [N-1:0]    cap_sel_s;
  logic [T-1:0]    cap_data_s;
  logic            in_range_s;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW:0] off);
    logic [PW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= M_L) begin
      sum = sum - M_L;
    end else begin
      sum = sum;
    end
    return sum[PW-1:0];
  endfunction

  function automatic logic [M-1:0] onehot(input logic [PW-1:0] idx);
    logic [M-1:0] v;
    v = '0;
    for (int j = 0; j < M; j++) begin
      if (PW'(j) == idx) begin
        v[j] = 1'b1;
      end else begin
        v[j] = 1'b0;
      end
    end
    return v;
  endfunction

  // Round-robin search starting at ptr for the first active request.
  always_comb begin
    logic [PW-1:0] cand;
    cand     = '0;
    found_s  = 1'b0;
    search_s = ptr_r;
    for (int i = 0; i < M; i++) begin
      cand = wrap_add(ptr_r, (PW+1)'(i));
      if (!found_s && bus.req[cand]) begin
        found_s  = 1'b1;
        search_s = cand;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Select and range-check the select/data of the requester about to be written.
  always_comb begin
`ifdef IO_ARB_LOCK_EN
    cap_idx_s = (state_r == LOCKED) ? grant_r : search_s;
`else
    cap_idx_s = search_s;
`endif
    cap_sel_s  = '0;
    cap_data_s = '0;
    for (int j = 0; j < M; j++) begin
      if (PW'(j) == cap_idx_s) begin
        cap_sel_s  = bus.req_sel[j*N +: N];
        cap_data_s = bus.req_data[j*T +: T];
      end else begin
        cap_sel_s  = cap_sel_s;
      end
    end
    in_range_s = ({1'b0, cap_sel_s} < R_L);
  end

  // Next-state and next-output logic for IDLE -> WRITE -> HOLD (-> LOCKED).
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    grant_s = grant_r;
    ack_s   = '0;
    err_s   = 1'b0;
    hab_s   = 1'b0;
    deco_s  = deco_r;
    data_s  = data_r;
`ifdef IO_ARB_LOCK_EN
    lockhold_s = lockhold_r;
`endif
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s = cap_idx_s;
          deco_s  = cap_sel_s;
          data_s  = cap_data_s;
          hab_s   = in_range_s;
          err_s   = !in_range_s;
          ack_s   = onehot(cap_idx_s);
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        state_s = HOLD;
`ifdef IO_ARB_LOCK_EN
        lockhold_s = lock[grant_r];
        if (lock[grant_r]) begin
          ptr_s = ptr_r;
        end else begin
          ptr_s = wrap_add(grant_r, (PW+1)'(1));
        end
`else
        ptr_s = wrap_add(grant_r, (PW+1)'(1));
`endif
      end
      HOLD: begin
`ifdef IO_ARB_LOCK_EN
        state_s = lockhold_r ? LOCKED : IDLE;
`else
        state_s = IDLE;
`endif
      end
`ifdef IO_ARB_LOCK_EN
      // Only the lock owner is served until it releases the lock while idle.
      LOCKED: begin
        if (bus.req[grant_r]) begin
          deco_s  = cap_sel_s;
          data_s  = cap_data_s;
          hab_s   = in_range_s;
          err_s   = !in_range_s;
          ack_s   = onehot(grant_r);
          state_s = WRITE;
        end else if (!lock[grant_r]) begin
          lockhold_s = 1'b0;
          state_s    = IDLE;
        end else begin
          state_s = LOCKED;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs; reset clears any write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
      ack_r   <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      hab_r   <= 1'b0;
      deco_r  <= '0;
      data_r  <= '0;
`ifdef IO_ARB_LOCK_EN
      lockhold_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      grant_r <= grant_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      hab_r   <= hab_s;
      deco_r  <= deco_s;
      data_r  <= data_s;
`ifdef IO_ARB_LOCK_EN
      lockhold_r <= lockhold_s;
`endif
    end
  end

  assign bus.ack         = ack_r;
  assign bus.err         = err_r;
  assign bus.busy        = busy_r;
  assign bus.habilitar   = hab_r;
  assign bus.entradaDeco = deco_r;
  assign bus.data_IO_out = data_r;

endmodule
